// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, ALU op codes,
// opcode/func constants and ALU operand-B select values.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_NOR  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_LUI  = 4'd8;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU-immediate opcodes occupy 0x08..0x0F.
    function automatic logic is_alu_imm(input logic [5:0] op_v);
        return op_v[5:3] == 3'b001;
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational decode of op/func into ALU operation, immediate extension mode
// and a legality flag for R-type and ALU-immediate instructions.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic       sz_en,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        sz_en  = 1'b0;
        legal  = 1'b0;
        if (op == OP_RTYPE) begin
            legal = 1'b1;
            case (func)
                FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                FN_AND:          alu_op = ALU_AND;
                FN_OR:           alu_op = ALU_OR;
                FN_XOR:          alu_op = ALU_XOR;
                FN_NOR:          alu_op = ALU_NOR;
                FN_SLT:          alu_op = ALU_SLT;
                FN_SLTU:         alu_op = ALU_SLTU;
                default:         legal  = 1'b0;
            endcase
        end else begin
            legal = 1'b1;
            case (op)
                OP_ADDI, OP_ADDIU: begin alu_op = ALU_ADD;  sz_en = 1'b1; end
                OP_SLTI:           begin alu_op = ALU_SLT;  sz_en = 1'b1; end
                OP_SLTIU:          begin alu_op = ALU_SLTU; sz_en = 1'b1; end
                OP_ANDI:           alu_op = ALU_AND;
                OP_ORI:            alu_op = ALU_OR;
                OP_XORI:           alu_op = ALU_XOR;
                OP_LUI:            alu_op = ALU_LUI;
                default:           legal  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore FSM sequencing a multi-cycle MIPS datapath, with wait-state stretching
// of every memory state and a sticky illegal-instruction flag.
module multi_cycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       alu_zero,
    output logic       pc_en,
    output logic       pc_src,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       sz_en,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       illegal_q;
    logic       is_load_q;
    logic       mem_state, wait_done;
    logic [3:0] dec_alu_op;
    logic       dec_sz_en, dec_legal;

    mips_alu_decode u_alu_decode (
        .op     (op),
        .func   (func),
        .alu_op (dec_alu_op),
        .sz_en  (dec_sz_en),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_d == S_HALT)
                illegal_q <= 1'b1;
            // MEM_ADDR must not look at op, so remember lw vs sw while decoding.
            if (state_q == S_DECODE)
                is_load_q <= (op == OP_LW);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        sz_en      = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        retire     = 1'b0;

        mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        wait_done = (cnt_q == WAIT_LAST);
        if (mem_state && !wait_done)
            cnt_d = cnt_q + 4'd1;

        case (state_q)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                if (wait_done) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                sz_en     = 1'b1;
                if (op == OP_RTYPE)
                    state_d = dec_legal ? S_EXEC_R : S_HALT;
                else if (is_alu_imm(op))
                    state_d = S_EXEC_I;
                else if (op == OP_LW || op == OP_SW)
                    state_d = S_MEM_ADDR;
                else if (op == OP_BEQ || op == OP_BNE)
                    state_d = S_BRANCH;
                else
                    state_d = S_HALT;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = dec_alu_op;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = dec_alu_op;
                sz_en     = dec_sz_en;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                sz_en     = 1'b1;
                state_d   = is_load_q ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord = 1'b1;
                if (wait_done)
                    state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                iord = 1'b1;
                if (wait_done) begin
                    mem_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_en     = (op == OP_BNE) ? !alu_zero : alu_zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        // Reset aborts the instruction at this edge, so no write may escape.
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed scoreboard bench: three controllers (MEM_WAIT 0/2/3) share stimulus;
// per-cycle expected output vectors are queued and compared against the selected one.
module tb_multi_cycle_ctrl;
    import mips_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic       pc_src;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       sz_en;
        logic       alu_src_a;
        logic [1:0] srcb;
        logic [3:0] aop;
        logic       retire;
        logic       illegal;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] func = '0;
    logic       alu_zero = 1'b0;

    logic       pc_en_w [3], pc_src_w [3], iord_w [3], ir_write_w [3], mem_write_w [3];
    logic       reg_write_w [3], reg_dst_w [3], mem_to_reg_w [3], sz_en_w [3], alu_src_a_w [3];
    logic       retire_w [3], illegal_w [3];
    logic [1:0] alu_src_b_w [3];
    logic [3:0] alu_op_w [3], state_w [3];

    int   checks = 0;
    int   fails = 0;
    int   sel = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        multi_cycle_ctrl #(.MEM_WAIT((gi == 0) ? 0 : ((gi == 1) ? 2 : 3))) u_dut (
            .clk        (clk),
            .reset      (reset),
            .op         (op),
            .func       (func),
            .alu_zero   (alu_zero),
            .pc_en      (pc_en_w[gi]),
            .pc_src     (pc_src_w[gi]),
            .iord       (iord_w[gi]),
            .ir_write   (ir_write_w[gi]),
            .mem_write  (mem_write_w[gi]),
            .reg_write  (reg_write_w[gi]),
            .reg_dst    (reg_dst_w[gi]),
            .mem_to_reg (mem_to_reg_w[gi]),
            .sz_en      (sz_en_w[gi]),
            .alu_src_a  (alu_src_a_w[gi]),
            .alu_src_b  (alu_src_b_w[gi]),
            .alu_op     (alu_op_w[gi]),
            .retire     (retire_w[gi]),
            .illegal    (illegal_w[gi]),
            .state      (state_w[gi])
        );
    end

    function automatic obs_t sample();
        obs_t o;
        o.st = state_w[sel];          o.pc_en = pc_en_w[sel];
        o.pc_src = pc_src_w[sel];     o.iord = iord_w[sel];
        o.ir_write = ir_write_w[sel]; o.mem_write = mem_write_w[sel];
        o.reg_write = reg_write_w[sel]; o.reg_dst = reg_dst_w[sel];
        o.mem_to_reg = mem_to_reg_w[sel]; o.sz_en = sz_en_w[sel];
        o.alu_src_a = alu_src_a_w[sel]; o.srcb = alu_src_b_w[sel];
        o.aop = alu_op_w[sel];        o.retire = retire_w[sel];
        o.illegal = illegal_w[sel];
        return o;
    endfunction

    function automatic obs_t base(state_t s, logic ill);
        obs_t o = '0;
        o.st = s;
        o.illegal = ill;
        return o;
    endfunction

    // Expected vectors per state, written straight from the control table.
    task automatic push_fetch(int w);
        obs_t o;
        for (int i = 0; i <= w; i++) begin
            o = base(S_FETCH, 1'b0); o.srcb = 2'b01;
            if (i == w) begin o.ir_write = 1'b1; o.pc_en = 1'b1; end
            exp_q.push_back(o);
        end
    endtask
    task automatic push_decode();
        obs_t o = base(S_DECODE, 1'b0);
        o.srcb = 2'b11; o.sz_en = 1'b1;
        exp_q.push_back(o);
    endtask
    task automatic push_exec_r(logic [3:0] aop);
        obs_t o = base(S_EXEC_R, 1'b0);
        o.alu_src_a = 1'b1; o.aop = aop;
        exp_q.push_back(o);
    endtask
    task automatic push_wb_r();
        obs_t o = base(S_WB_R, 1'b0);
        o.reg_dst = 1'b1; o.reg_write = 1'b1; o.retire = 1'b1;
        exp_q.push_back(o);
    endtask
    task automatic push_exec_i(logic [3:0] aop, logic sz);
        obs_t o = base(S_EXEC_I, 1'b0);
        o.alu_src_a = 1'b1; o.srcb = 2'b10; o.aop = aop; o.sz_en = sz;
        exp_q.push_back(o);
    endtask
    task automatic push_wb_i();
        obs_t o = base(S_WB_I, 1'b0);
        o.reg_write = 1'b1; o.retire = 1'b1;
        exp_q.push_back(o);
    endtask
    task automatic push_mem_addr();
        obs_t o = base(S_MEM_ADDR, 1'b0);
        o.alu_src_a = 1'b1; o.srcb = 2'b10; o.sz_en = 1'b1;
        exp_q.push_back(o);
    endtask
    task automatic push_mem_rd(int n);
        obs_t o = base(S_MEM_RD, 1'b0);
        o.iord = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(o);
    endtask
    task automatic push_mem_wb();
        obs_t o = base(S_MEM_WB, 1'b0);
        o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.retire = 1'b1;
        exp_q.push_back(o);
    endtask
    task automatic push_mem_wr(int w);
        obs_t o;
        for (int i = 0; i <= w; i++) begin
            o = base(S_MEM_WR, 1'b0); o.iord = 1'b1;
            if (i == w) begin o.mem_write = 1'b1; o.retire = 1'b1; end
            exp_q.push_back(o);
        end
    endtask
    task automatic push_branch(logic taken);
        obs_t o = base(S_BRANCH, 1'b0);
        o.alu_src_a = 1'b1; o.aop = 4'd1; o.pc_src = 1'b1; o.pc_en = taken; o.retire = 1'b1;
        exp_q.push_back(o);
    endtask
    task automatic push_halt(int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base(S_HALT, 1'b1));
    endtask

    // Called just after a negedge; each queued vector is checked 1 time unit later.
    task automatic run(string tag);
        obs_t e, a;
        int cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            a = sample();
            cyc++;
            checks++;
            assert (a === e) else begin
                fails++;
                $error("FAIL %s inst%0d cyc%0d observed=%h expected=%h", tag, sel, cyc, a, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic restart(int s, logic [5:0] o, logic [5:0] f, logic z);
        sel = s;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        op = o; func = f; alu_zero = z;
    endtask

    typedef struct { logic [5:0] code; logic [3:0] aop; logic sz; } dec_t;
    dec_t rfn [5];
    dec_t imm [5];

    initial begin
        rfn = '{'{6'h20, 4'd0, 1'b0}, '{6'h22, 4'd1, 1'b0}, '{6'h25, 4'd5, 1'b0},
                '{6'h27, 4'd6, 1'b0}, '{6'h2B, 4'd3, 1'b0}};
        imm = '{'{6'h0C, 4'd4, 1'b0}, '{6'h0B, 4'd3, 1'b1}, '{6'h0F, 4'd8, 1'b0},
                '{6'h08, 4'd0, 1'b1}, '{6'h0E, 4'd7, 1'b0}};

        // Reset held: FETCH, strobes suppressed, illegal clear.
        sel = 0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        begin
            obs_t o = base(S_FETCH, 1'b0);
            o.srcb = 2'b01;
            exp_q.push_back(o);
        end
        run("reset_hold");

        // R-type sweep, 4 cycles each, retire on the 4th.
        foreach (rfn[i]) begin
            restart(0, 6'h00, rfn[i].code, 1'b0);
            push_fetch(0); push_decode(); push_exec_r(rfn[i].aop); push_wb_r(); push_fetch(0);
            run("rtype");
        end

        // ALU-immediate sweep.
        foreach (imm[i]) begin
            restart(0, imm[i].code, 6'h00, 1'b0);
            push_fetch(0); push_decode(); push_exec_i(imm[i].aop, imm[i].sz); push_wb_i();
            run("imm");
        end

        // lw with MEM_WAIT=3: 4 fetch + decode + addr + 4 read + wb = 11 cycles.
        restart(2, 6'h23, 6'h3F, 1'b0);
        push_fetch(3); push_decode(); push_mem_addr(); push_mem_rd(4); push_mem_wb(); push_fetch(3);
        run("lw_w3");

        restart(0, 6'h23, 6'h00, 1'b0);
        push_fetch(0); push_decode(); push_mem_addr(); push_mem_rd(1); push_mem_wb();
        run("lw_w0");

        restart(0, 6'h2B, 6'h00, 1'b0);
        push_fetch(0); push_decode(); push_mem_addr(); push_mem_wr(0); push_fetch(0);
        run("sw_w0");

        restart(1, 6'h2B, 6'h00, 1'b0);
        push_fetch(2); push_decode(); push_mem_addr(); push_mem_wr(2);
        run("sw_w2");

        // Branches: beq/bne against both zero values, 3 cycles each.
        restart(0, 6'h04, 6'h00, 1'b1);
        push_fetch(0); push_decode(); push_branch(1'b1); push_fetch(0);
        run("beq_z1");
        restart(0, 6'h04, 6'h00, 1'b0);
        push_fetch(0); push_decode(); push_branch(1'b0);
        run("beq_z0");
        restart(0, 6'h05, 6'h00, 1'b1);
        push_fetch(0); push_decode(); push_branch(1'b0); push_fetch(0);
        run("bne_z1");
        restart(0, 6'h05, 6'h00, 1'b0);
        push_fetch(0); push_decode(); push_branch(1'b1);
        run("bne_z0");

        // Illegal opcode: HALT is terminal and flagged; reset recovers.
        restart(0, 6'h3F, 6'h00, 1'b0);
        push_fetch(0); push_decode(); push_halt(20);
        run("halt_op");
        reset = 1'b1;
        push_halt(1);
        run("halt_in_reset");
        reset = 1'b0;
        push_fetch(0); push_decode();
        run("after_halt");

        // Illegal R-type func also halts.
        restart(0, 6'h00, 6'h00, 1'b0);
        push_fetch(0); push_decode(); push_halt(3);
        run("halt_func");

        // Reset mid-MEM_RD with MEM_WAIT=2: no writes, restart in FETCH.
        restart(1, 6'h23, 6'h00, 1'b0);
        push_fetch(2); push_decode(); push_mem_addr(); push_mem_rd(1);
        run("lw_w2_pre");
        reset = 1'b1;
        push_mem_rd(1);
        run("rst_in_memrd");
        reset = 1'b0;
        push_fetch(2); push_decode(); push_mem_addr();
        run("after_memrd_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
